// File: rtl/committed_store_buffer.sv
// Committed store buffer: FIFO of architecturally committed stores drained to the d-cache write port
// in cycles not used by loads. Optional store-to-load forwarding is enabled by defining STORE_FWD_EN.
module committed_store_buffer #(
    parameter int SB_DEPTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cm_valid,
    input  logic [ADDR_WIDTH-1:0]     cm_addr,
    input  logic [DATA_WIDTH-1:0]     cm_data,
    output logic                      cm_ready,
    input  logic                      ld_req_valid,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    output logic                      ld_conflict,
    output logic                      ld_fwd_valid,
    output logic [DATA_WIDTH-1:0]     ld_fwd_data,
    input  logic                      drain_req,
    input  logic                      cache_stall,
    output logic                      cache_wr_valid,
    output logic [ADDR_WIDTH-1:0]     cache_wr_addr,
    output logic [DATA_WIDTH-1:0]     cache_wr_data,
    output logic                      sb_empty,
    output logic [$clog2(SB_DEPTH):0] sb_count
);

    localparam int PW = $clog2(SB_DEPTH);

    logic [ADDR_WIDTH-1:0] addr_mem_r [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid_r;
    logic [PW:0]           wr_ptr_r;
    logic [PW:0]           rd_ptr_r;
    logic                  cache_wr_valid_r;
    logic [ADDR_WIDTH-1:0] cache_wr_addr_r;
    logic [DATA_WIDTH-1:0] cache_wr_data_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          issue_s;
    logic          conflict_any_s;
    logic [PW-1:0] rd_idx_s;
    logic [PW-1:0] wr_idx_s;

    assign rd_idx_s = rd_ptr_r[PW-1:0];
    assign wr_idx_s = wr_ptr_r[PW-1:0];
    assign full_s   = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    // A full buffer refuses commits even while it pops, so the ROB never sees a same-cycle refill.
    assign push_s   = cm_valid & ~full_s;
    // Loads own the cache port unless a fence/halt asks for drain or the buffer is full.
    assign issue_s  = ~cache_stall & ~empty_s & (~ld_req_valid | drain_req | full_s);

    // Entry storage and pointers: push writes the tail, issue retires the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
                data_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            valid_r  <= {SB_DEPTH{1'b0}};
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (issue_s) begin
                valid_r[rd_idx_s] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (push_s) begin
                addr_mem_r[wr_idx_s] <= cm_addr;
                data_mem_r[wr_idx_s] <= cm_data;
                valid_r[wr_idx_s]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Registered d-cache write request; a stalled cache stage freezes it entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_wr_valid_r <= 1'b0;
            cache_wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            cache_wr_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (!cache_stall) begin
            if (issue_s) begin
                cache_wr_valid_r <= 1'b1;
                cache_wr_addr_r  <= addr_mem_r[rd_idx_s];
                cache_wr_data_r  <= data_mem_r[rd_idx_s];
            end else begin
                cache_wr_valid_r <= 1'b0;
            end
        end
    end

    // Address match against every buffered entry and the in-flight write.
    always_comb begin
        conflict_any_s = cache_wr_valid_r & (cache_wr_addr_r == ld_addr);
        for (int i = 0; i < SB_DEPTH; i++) begin
            conflict_any_s = conflict_any_s | (valid_r[i] & (addr_mem_r[i] == ld_addr));
        end
    end

    assign ld_conflict    = ld_req_valid & conflict_any_s;
    assign cm_ready       = ~full_s;
    assign sb_empty       = empty_s & ~cache_wr_valid_r;
    assign sb_count       = wr_ptr_r - rd_ptr_r;
    assign cache_wr_valid = cache_wr_valid_r;
    assign cache_wr_addr  = cache_wr_addr_r;
    assign cache_wr_data  = cache_wr_data_r;

`ifdef STORE_FWD_EN
    logic                  fwd_hit_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;
    logic [PW-1:0]         age_idx_s;
    logic                  age_match_s;

    // Walk entries oldest to youngest from the head so the last match is the youngest store.
    always_comb begin
        fwd_hit_s   = cache_wr_valid_r & (cache_wr_addr_r == ld_addr);
        fwd_data_s  = fwd_hit_s ? cache_wr_data_r : {DATA_WIDTH{1'b0}};
        age_idx_s   = rd_idx_s;
        age_match_s = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            age_idx_s   = rd_idx_s + PW'(i);
            age_match_s = valid_r[age_idx_s] & (addr_mem_r[age_idx_s] == ld_addr);
            fwd_data_s  = age_match_s ? data_mem_r[age_idx_s] : fwd_data_s;
            fwd_hit_s   = fwd_hit_s | age_match_s;
        end
    end

    assign ld_fwd_valid = ld_req_valid & fwd_hit_s;
    assign ld_fwd_data  = (ld_req_valid & fwd_hit_s) ? fwd_data_s : {DATA_WIDTH{1'b0}};
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_committed_store_buffer.sv
// Scoreboarded bench for committed_store_buffer: a queue-based reference model predicts buffer
// state each cycle; a monitor pops commit-ordered expected writes whenever the cache sees a new write.
module tb_committed_store_buffer;
    localparam int SB_DEPTH = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cm_valid, cm_ready;
    logic [AW-1:0] cm_addr;
    logic [DW-1:0] cm_data;
    logic          ld_req_valid, ld_conflict, ld_fwd_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_fwd_data;
    logic          drain_req, cache_stall;
    logic          cache_wr_valid;
    logic [AW-1:0] cache_wr_addr;
    logic [DW-1:0] cache_wr_data;
    logic          sb_empty;
    logic [$clog2(SB_DEPTH):0] sb_count;

    committed_store_buffer #(.SB_DEPTH(SB_DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_addr(cm_addr), .cm_data(cm_data), .cm_ready(cm_ready),
        .ld_req_valid(ld_req_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
        .drain_req(drain_req), .cache_stall(cache_stall),
        .cache_wr_valid(cache_wr_valid), .cache_wr_addr(cache_wr_addr), .cache_wr_data(cache_wr_data),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } st_t;

    st_t           mq[$];     // model buffer contents, oldest first
    st_t           exp_q[$];  // scoreboard: every accepted store, in commit order
    logic          mo_v = 1'b0;
    logic [AW-1:0] mo_a = '0;
    logic [DW-1:0] mo_d = '0;
    logic          prev_stall = 1'b0;
    st_t           mon_e;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a valid write after a non-stalled cycle is a newly issued write.
    always @(negedge clk) begin
        if (!rst && cache_wr_valid && !prev_stall) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", cache_wr_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", cache_wr_addr, mon_e.a);
                chk("wr_data", cache_wr_data, mon_e.d);
            end
        end
        prev_stall = cache_stall;
    end

    task automatic cyc(input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic lv, input logic [AW-1:0] la, input logic dr, input logic st);
        bit            full, iss, conf;
        logic [DW-1:0] fd;
        st_t           e;
        cm_valid = cv; cm_addr = ca; cm_data = cd;
        ld_req_valid = lv; ld_addr = la; drain_req = dr; cache_stall = st;
        @(negedge clk);
        full = (mq.size() == SB_DEPTH);
        chk("cm_ready", cm_ready, !full);
        chk("sb_count", sb_count, mq.size());
        chk("sb_empty", sb_empty, (mq.size() == 0) && !mo_v);
        chk("wr_valid", cache_wr_valid, mo_v);
        if (mo_v) begin
            chk("wr_addr_hold", cache_wr_addr, mo_a);
            chk("wr_data_hold", cache_wr_data, mo_d);
        end
        conf = mo_v && (mo_a == la);
        fd = conf ? mo_d : '0;
        foreach (mq[i]) begin
            if (mq[i].a == la) begin
                conf = 1'b1;
                fd = mq[i].d;
            end
        end
        conf = conf && lv;
        chk("ld_conflict", ld_conflict, conf);
`ifdef STORE_FWD_EN
        chk("ld_fwd_valid", ld_fwd_valid, conf);
        chk("ld_fwd_data", ld_fwd_data, conf ? fd : '0);
`else
        chk("ld_fwd_valid", ld_fwd_valid, 1'b0);
        chk("ld_fwd_data", ld_fwd_data, '0);
`endif
        iss = !st && (mq.size() > 0) && (!lv || dr || full);
        if (iss) begin
            e = mq.pop_front();
            mo_v = 1'b1; mo_a = e.a; mo_d = e.d;
        end else if (!st) begin
            mo_v = 1'b0;
        end
        if (cv && !full) begin
            mq.push_back({ca, cd});
            exp_q.push_back({ca, cd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cm_valid = 1'b0; cm_addr = '0; cm_data = '0;
        ld_req_valid = 1'b0; ld_addr = '0; drain_req = 1'b0; cache_stall = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_wr_valid", cache_wr_valid, 1'b0);
        chk("rst_wr_addr", cache_wr_addr, '0);
        chk("rst_wr_data", cache_wr_data, '0);
        chk("rst_cm_ready", cm_ready, 1'b1);
        chk("rst_sb_empty", sb_empty, 1'b1);
        chk("rst_sb_count", sb_count, '0);
        chk("rst_ld_conflict", ld_conflict, 1'b0);
        chk("rst_ld_fwd_valid", ld_fwd_valid, 1'b0);
        mq.delete();
        exp_q.delete();
        mo_v = 1'b0; mo_a = '0; mo_d = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        do_reset();

        // single store with no loads
        cyc(1'b1, 32'h100, 32'hA, 1'b0, '0, 1'b0, 1'b0);
        idle(4);

        // fill with loads hogging the port; full forces drains, 9th push refused
        for (int i = 0; i < 9; i++)
            cyc(1'b1, 32'h400 + 32'(i) * 32'd4, 32'h50 + 32'(i), 1'b1, 32'h900, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 32'h900, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 32'h900, 1'b1, 1'b0);
        idle(12);

        // two stores to the same word, then a load to it
        cyc(1'b1, 32'h200, 32'h1, 1'b1, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h200, 32'h2, 1'b1, 32'h200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 32'h200, 1'b0, 1'b0);
        idle(5);

        // stall with a write pending, then release
        cyc(1'b1, 32'h300, 32'h11, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 32'h22, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 32'h304, 1'b0, 1'b1);
        idle(5);

        // reset with four entries buffered and a write in flight
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h500 + 32'(i) * 32'd4, 32'h70 + 32'(i), 1'b1, 32'h900, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        do_reset();

        // twelve stores interleaved with drains, wrapping the pointers
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 32'h600 + 32'(i) * 32'd4, 32'h90 + 32'(i), 1'b0, '0, 1'b0, 1'b0);
            if (i % 3 == 2) idle(1);
        end
        idle(6);

        // randomized traffic over a small address set to provoke conflicts
        for (int n = 0; n < 1500; n++) begin
            ra = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            cyc(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7)) * 32'd4, $urandom,
                1'($urandom_range(0, 1)), ra,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
        end
        idle(30);
        chk("drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
